// File: rtl/serial_tx_shifter.sv
// Parallel-in, serial-out frame transmitter: start bit (0), DATA_W data bits LSB first,
// stop bit (1), each bit held on tx for CLKS_PER_BIT clocks.
module serial_tx_shifter #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] data_in,
    output logic              tx,
    output logic              busy,
    output logic              done,
    output logic [1:0]        state_dbg
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BAUD_W-1:0] LAST_BAUD = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    state_t              state, state_next;
    logic [DATA_W-1:0]   shift_reg, shift_next;
    logic [BIT_W-1:0]    bit_cnt, bit_cnt_next;
    logic [BAUD_W-1:0]   baud_cnt, baud_next;
    logic                tx_next, busy_next, done_next;
    logic                bit_end;
    logic [DATA_W-1:0]   shift_dn;

    // Request handshake: start is a level request that is only honoured on an edge
    // where the transmitter is IDLE; that edge captures data_in. There is no ready
    // output -- busy low means the next edge will accept start, and requests made
    // while busy are dropped rather than queued.

    assign bit_end   = (baud_cnt == LAST_BAUD);
    assign shift_dn  = shift_reg >> 1;
    assign state_dbg = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            shift_reg <= '0;
            bit_cnt   <= '0;
            baud_cnt  <= '0;
            tx        <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_next;
            shift_reg <= shift_next;
            bit_cnt   <= bit_cnt_next;
            baud_cnt  <= baud_next;
            tx        <= tx_next;
            busy      <= busy_next;
            done      <= done_next;
        end
    end

    // tx/busy/done are computed one cycle ahead so the ports come straight off flops.
    always_comb begin
        state_next   = state;
        shift_next   = shift_reg;
        bit_cnt_next = bit_cnt;
        baud_next    = bit_end ? '0 : baud_cnt + BAUD_W'(1);
        tx_next      = tx;
        busy_next    = busy;
        done_next    = 1'b0;

        unique case (state)
            ST_IDLE: begin
                tx_next   = 1'b1;
                busy_next = 1'b0;
                baud_next = '0;
                if (start) begin
                    state_next   = ST_START;
                    shift_next   = data_in;
                    bit_cnt_next = '0;
                    tx_next      = 1'b0;
                    busy_next    = 1'b1;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_next   = ST_DATA;
                    bit_cnt_next = '0;
                    tx_next      = shift_reg[0];
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    if (bit_cnt == LAST_BIT) begin
                        state_next = ST_STOP;
                        tx_next    = 1'b1;
                    end else begin
                        shift_next   = shift_dn;
                        tx_next      = shift_dn[0];
                        bit_cnt_next = bit_cnt + BIT_W'(1);
                    end
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    state_next = ST_IDLE;
                    tx_next    = 1'b1;
                    busy_next  = 1'b0;
                    done_next  = 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
                tx_next    = 1'b1;
                busy_next  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_serial_tx_shifter.sv
// Directed bench for serial_tx_shifter: one instance at 4 clocks/bit, one at 1 clock/bit,
// sharing stimulus; outputs sampled on the falling edge.
module tb_serial_tx_shifter;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] data_in;
    logic       tx0, busy0, done0;
    logic       tx1, busy1, done1;
    logic [1:0] st0, st1;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int done_a, done_b;

    serial_tx_shifter #(.DATA_W(8), .CLKS_PER_BIT(4)) dut (
        .clk(clk), .rst(rst), .start(start), .data_in(data_in),
        .tx(tx0), .busy(busy0), .done(done0), .state_dbg(st0)
    );

    serial_tx_shifter #(.DATA_W(8), .CLKS_PER_BIT(1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .data_in(data_in),
        .tx(tx1), .busy(busy1), .done(done1), .state_dbg(st1)
    );

    // clock/reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %b want %b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    // Called at the falling edge just after the accepting edge; bits[k] is the k-th
    // transmitted bit. Ends at the falling edge after the done edge.
    task automatic expect_frame(input string tag, input bit sel, input logic [9:0] bits,
                                input int cpb, input int inject_at, input bit keep,
                                output int done_cyc);
        for (int k = 0; k < 10 * cpb; k++) begin
            chk({tag, "_tx"},   sel ? tx1 : tx0, bits[k / cpb]);
            chk({tag, "_busy"}, sel ? busy1 : busy0, 1'b1);
            chk({tag, "_done"}, sel ? done1 : done0, 1'b0);
            if (k == inject_at) begin
                start   = 1'b1;
                data_in = 8'hFF;
            end else if (!keep) begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        chk({tag, "_end_done"}, sel ? done1 : done0, 1'b1);
        chk({tag, "_end_busy"}, sel ? busy1 : busy0, 1'b0);
        chk({tag, "_end_tx"},   sel ? tx1 : tx0, 1'b1);
        done_cyc = cyc;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int dummy;
        // 1: reset held 5 cycles with random inputs
        rst     = 1'b1;
        start   = 1'b0;
        data_in = 8'h00;
        for (int i = 0; i < 5; i++) begin
            start   = 1'($urandom_range(0, 1));
            data_in = 8'($urandom_range(0, 255));
            @(negedge clk);
            chk("rst_tx",   tx0,   1'b1);
            chk("rst_busy", busy0, 1'b0);
            chk("rst_done", done0, 1'b0);
            chk("rst_tx1",  tx1,   1'b1);
        end
        start = 1'b0;
        rst   = 1'b0;
        idle(3);
        chk("idle_tx", tx0, 1'b1);

        // 2: single A5 frame
        start   = 1'b1;
        data_in = 8'hA5;
        @(negedge clk);
        expect_frame("a5", 1'b0, 10'b11_0100_1010, 4, -1, 1'b0, dummy);
        @(negedge clk);
        chk("a5_done_once", done0, 1'b0);
        chk("a5_idle_tx",   tx0,   1'b1);
        idle(20);

        // 3: start with FF at cycle 12 ignored, data_in change ignored
        start   = 1'b1;
        data_in = 8'hA5;
        @(negedge clk);
        expect_frame("mid", 1'b0, 10'b11_0100_1010, 4, 12, 1'b0, dummy);
        @(negedge clk);
        chk("mid_done_once", done0, 1'b0);
        chk("mid_busy",      busy0, 1'b0);
        idle(20);

        // 4: start held high, back-to-back 00 then 3C
        start   = 1'b1;
        data_in = 8'h00;
        @(negedge clk);
        data_in = 8'h3C;
        expect_frame("b2b0", 1'b0, 10'b10_0000_0000, 4, -1, 1'b1, done_a);
        @(negedge clk);
        expect_frame("b2b1", 1'b0, 10'b10_0111_1000, 4, -1, 1'b0, done_b);
        chk32("b2b_gap", done_b - done_a, 41);
        idle(20);

        // 5: reset at cycle 15 of a frame, then 5A
        start   = 1'b1;
        data_in = 8'hA5;
        @(negedge clk);
        start = 1'b0;
        repeat (15) @(negedge clk);
        chk("pre_rst_busy", busy0, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_tx",   tx0,   1'b1);
        chk("async_rst_busy", busy0, 1'b0);
        chk("async_rst_done", done0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            chk("post_rst_done", done0, 1'b0);
            chk("post_rst_tx",   tx0,   1'b1);
        end
        start   = 1'b1;
        data_in = 8'h5A;
        @(negedge clk);
        expect_frame("5a", 1'b0, 10'b10_1011_0100, 4, -1, 1'b0, dummy);
        idle(20);

        // 6: one clock per bit, 81
        start   = 1'b1;
        data_in = 8'h81;
        @(negedge clk);
        expect_frame("c1", 1'b1, 10'b11_0000_0010, 1, -1, 1'b0, dummy);
        @(negedge clk);
        chk("c1_done_once", done1, 1'b0);
        idle(45);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // hard time limit so the run always terminates
    initial begin
        #200000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

endmodule
